// File: rtl/regfile_hilo.sv
// regfile_hilo: architectural register state at the end of the write-back path.
// Holds 32 general-purpose registers plus the HI/LO pair. Commits the register
// and HI/LO writes that arrive from the mem/wb pipeline register. Serves two GPR
// read ports and the HI/LO read port, all combinational. A write that is being
// committed in the current cycle is forwarded straight to the readers.
//
// Ports:
//   clock              rising-edge clock for all state updates
//   reset              asynchronous, active-low reset
//   write_enable       GPR write request
//   write_addr         GPR write address (a write to 0 is discarded)
//   write_data         GPR write data
//   write_hilo_enable  HI/LO write request (updates both halves)
//   write_hi_data      HI write value
//   write_lo_data      LO write value
//   read_enable_1/2    GPR read-port enables
//   read_addr_1/2      GPR read addresses
//   read_data_1/2      GPR read data, with write bypass
//   hi_data, lo_data   current HI/LO, with write bypass
module regfile_hilo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned REG_COUNT  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_hilo_enable,
   input  logic [DATA_WIDTH-1:0] write_hi_data,
   input  logic [DATA_WIDTH-1:0] write_lo_data,
   input  logic                  read_enable_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   input  logic                  read_enable_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic [DATA_WIDTH-1:0] hi_data,
   output logic [DATA_WIDTH-1:0] lo_data
);

   logic [DATA_WIDTH-1:0] gpr_q [REG_COUNT];
   logic [DATA_WIDTH-1:0] hi_q;
   logic [DATA_WIDTH-1:0] lo_q;

   logic gpr_write;
   assign gpr_write = write_enable && (write_addr != '0);

   // GPR array. Entry 0 is never written, so it stays at its reset value of 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(REG_COUNT); i++) begin
            gpr_q[i] <= '0;
         end
      end else if (gpr_write) begin
         gpr_q[write_addr] <= write_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (write_hilo_enable) begin
         hi_q <= write_hi_data;
         lo_q <= write_lo_data;
      end
   end

   // Read port 1. Address 0 is checked before the bypass so that a discarded
   // write to register 0 can never leak onto the port.
   always_comb begin
      read_data_1 = '0;
      if (!reset || !read_enable_1 || (read_addr_1 == '0)) begin
         read_data_1 = '0;
      end else if (write_enable && (write_addr == read_addr_1)) begin
         read_data_1 = write_data;
      end else begin
         read_data_1 = gpr_q[read_addr_1];
      end
   end

   // Read port 2, same priority as port 1.
   always_comb begin
      read_data_2 = '0;
      if (!reset || !read_enable_2 || (read_addr_2 == '0)) begin
         read_data_2 = '0;
      end else if (write_enable && (write_addr == read_addr_2)) begin
         read_data_2 = write_data;
      end else begin
         read_data_2 = gpr_q[read_addr_2];
      end
   end

   always_comb begin
      hi_data = '0;
      lo_data = '0;
      if (!reset) begin
         hi_data = '0;
         lo_data = '0;
      end else if (write_hilo_enable) begin
         hi_data = write_hi_data;
         lo_data = write_lo_data;
      end else begin
         hi_data = hi_q;
         lo_data = lo_q;
      end
   end

endmodule
